// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 frame receiver with E0/F0 folding, watchdog and event FIFO
module ps2_scan_receiver #(
    parameter int FIFO_DEPTH     = 16,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          out_ready,
    input  logic                          clr_ovf,
    output logic                          out_valid,
    output logic [9:0]                    out_code,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic [7:0]                    err_cnt,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [3:0]             bit_cnt;
    logic [9:0]             shreg;
    logic [WW-1:0]          wd;
    logic                   ext_pend;
    logic                   brk_pend;
    logic [9:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          count;

    logic       fall;
    logic       din;
    logic       last_edge;
    logic       frame_ok;
    logic       frame_bad;
    logic       wd_abort;
    logic [7:0] rx_byte;
    logic       is_prefix;
    logic       emit;
    logic       pop;
    logic       full;
    logic       push_ok;
    logic       drop;

    // Equal-length synchronisers; both reset to the idle (high) bus level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign fall      = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
    assign din       = data_sync[SYNC_STAGES-1];
    assign last_edge = fall && (bit_cnt == 4'd10);
    // shreg holds start at [0], d0..d7 at [8:1], parity at [9]; the stop bit is the live sample
    assign frame_ok  = last_edge && !shreg[0] && din && (^shreg[9:1]);
    assign frame_bad = last_edge && !frame_ok;
    assign wd_abort  = (bit_cnt != 4'd0) && !fall && (wd == WD_LIMIT);
    assign rx_byte   = shreg[8:1];
    assign is_prefix = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
    assign emit      = frame_ok && !is_prefix;

    // Bit shifter and frame position counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 4'd0;
            shreg   <= 10'd0;
        end else if (fall) begin
            shreg   <= {din, shreg[9:1]};
            bit_cnt <= last_edge ? 4'd0 : bit_cnt + 4'd1;
        end else if (wd_abort) begin
            bit_cnt <= 4'd0;
        end
    end

    // Inter-edge watchdog, only counts while a frame is open
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd <= '0;
        end else if (fall || (bit_cnt == 4'd0) || wd_abort) begin
            wd <= '0;
        end else begin
            wd <= wd + WW'(1);
        end
    end

    // Saturating error counter for rejected or aborted frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if ((frame_bad || wd_abort) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    // Prefix tracking; a bad frame forgets pending prefixes, a timeout keeps them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (frame_bad) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (frame_ok) begin
            if (rx_byte == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    assign pop     = out_valid && out_ready;
    assign full    = (count == FULL_LVL);
    assign push_ok = emit && (!full || pop);
    assign drop    = emit && full && !pop;

    // Event storage; no reset needed since reads are qualified by out_valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {ext_pend, brk_pend, rx_byte};
        end
    end

    // FIFO pointers and occupancy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + LW'(1);
            end else if (pop && !push_ok) begin
                count <= count - LW'(1);
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as clr_ovf keeps it set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign out_valid = (count != '0);
    assign out_code  = mem[rd_ptr];
    assign level     = count;
    assign busy      = (bit_cnt != 4'd0);

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb/tb_ps2_scan_receiver.sv - self-checking bench for ps2_scan_receiver
module tb_ps2_scan_receiver;

    localparam int DEPTH = 4;
    localparam int SYNC  = 3;
    localparam int TMO   = 100;
    localparam int H     = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       out_ready;
    logic       clr_ovf;
    logic       out_valid;
    logic [9:0] out_code;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] err_cnt;
    logic       busy;

    ps2_scan_receiver #(
        .FIFO_DEPTH(DEPTH),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .out_ready(out_ready),
        .clr_ovf(clr_ovf),
        .out_valid(out_valid),
        .out_code(out_code),
        .level(level),
        .overflow(overflow),
        .err_cnt(err_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         kind;
        int         exp_level;
        logic [9:0] exp_head;
        int         exp_err;
        bit         drain;
    } vec_t;

    vec_t       tbl [13];
    int         n_vec = 0;
    int         n_miss = 0;
    int         lat = 0;
    logic [9:0] popped_code;
    logic [9:0] mq [$];
    bit         m_ext, m_brk, m_ovf;
    int         m_err;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
    function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
        logic par;
        logic start;
        logic stop;
        par   = ~^b;
        start = 1'b0;
        stop  = 1'b1;
        if (kind == 1) par = ~par;
        if (kind == 2) stop = 1'b0;
        if (kind == 3) start = 1'b1;
        return {stop, par, b, start};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ext = 0;
        m_brk = 0;
        m_ovf = 0;
        m_err = 0;
    endtask

    task automatic model_err();
        m_err = (m_err < 255) ? m_err + 1 : 255;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit ok, output bit dropped);
        dropped = 0;
        if (!ok) begin
            model_err();
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, b});
            else begin
                m_ovf   = 1;
                dropped = 1;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // act: 0 nothing, 1 pop in the final-bit detection cycle, 2 clr_ovf in that cycle
    task automatic send_bits(input logic [10:0] bits, input int n, input int act);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            for (int j = 1; j <= H; j++) begin
                @(negedge clk);
                if (lat == 0 && i == 0 && busy) lat = j;
                if (i == n - 1 && act != 0 && lat > 1) begin
                    if (j == lat - 1) begin
                        if (act == 1) begin
                            popped_code = out_code;
                            out_ready   = 1'b1;
                        end else begin
                            clr_ovf = 1'b1;
                        end
                    end else if (j == lat) begin
                        out_ready = 1'b0;
                        clr_ovf   = 1'b0;
                    end
                end
            end
            if (i == 0 && lat == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL busy_rise: busy never rose within %0d cycles of first edge", H);
            end
            ps2_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int kind, input int act);
        bit dropped;
        send_bits(make_frame(b, kind), 11, act);
        repeat (4) @(negedge clk);
        if (act == 1) begin
            if (mq.size() > 0) check("pop_on_push_code", popped_code, mq.pop_front());
        end
        model_frame(b, kind == 0, dropped);
        if (act == 2 && !dropped) m_ovf = 0;
    endtask

    task automatic check_state(input string name);
        check({name, "_level"}, level, mq.size());
        check({name, "_valid"}, out_valid, mq.size() > 0);
        check({name, "_err"}, err_cnt, m_err);
        check({name, "_ovf"}, overflow, m_ovf);
        if (mq.size() > 0) check({name, "_head"}, out_code, mq[0]);
    endtask

    task automatic pop_one();
        logic [9:0] got;
        got = out_code;
        check("pop_valid", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (mq.size() > 0) check("pop_code", got, mq.pop_front());
    endtask

    task automatic drain_all();
        while (mq.size() > 0) pop_one();
        @(negedge clk);
        check("drain_level", level, 0);
        check("drain_valid", out_valid, 0);
    endtask

    task automatic pulse_clr();
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        m_ovf   = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         kind;
        int         sel;

        tbl[0]  = '{8'h1C, 0, 1, 10'h01C, 0, 1'b1};
        tbl[1]  = '{8'hE0, 0, 0, 10'h000, 0, 1'b0};
        tbl[2]  = '{8'hF0, 0, 0, 10'h000, 0, 1'b0};
        tbl[3]  = '{8'h74, 0, 1, 10'h374, 0, 1'b1};
        tbl[4]  = '{8'h1C, 0, 1, 10'h01C, 0, 1'b1};
        tbl[5]  = '{8'h1C, 1, 0, 10'h000, 1, 1'b0};
        tbl[6]  = '{8'h1C, 2, 0, 10'h000, 2, 1'b0};
        tbl[7]  = '{8'hE0, 0, 0, 10'h000, 2, 1'b0};
        tbl[8]  = '{8'h6B, 3, 0, 10'h000, 3, 1'b0};
        tbl[9]  = '{8'h6B, 0, 1, 10'h06B, 3, 1'b1};
        tbl[10] = '{8'hF0, 0, 0, 10'h000, 3, 1'b0};
        tbl[11] = '{8'hE0, 0, 0, 10'h000, 3, 1'b0};
        tbl[12] = '{8'h5A, 0, 1, 10'h35A, 3, 1'b1};

        rst       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_state("reset");
        check("reset_busy", busy, 0);

        for (int v = 0; v < 13; v++) begin
            send_frame(tbl[v].b, tbl[v].kind, 0);
            check($sformatf("tbl%0d_level", v), level, tbl[v].exp_level);
            check($sformatf("tbl%0d_valid", v), out_valid, tbl[v].exp_level != 0);
            check($sformatf("tbl%0d_err", v), err_cnt, tbl[v].exp_err);
            check($sformatf("tbl%0d_busy", v), busy, 0);
            if (tbl[v].exp_level != 0) check($sformatf("tbl%0d_head", v), out_code, tbl[v].exp_head);
            if (tbl[v].drain) drain_all();
        end

        send_bits(make_frame(8'h55, 0), 5, 0);
        repeat (2) @(negedge clk);
        check("wd_busy_mid", busy, 1);
        repeat (TMO + 10) @(negedge clk);
        model_err();
        check("wd_busy_after", busy, 0);
        check("wd_err", err_cnt, m_err);
        send_frame(8'h2A, 0, 0);
        check_state("wd_next");
        drain_all();

        pulse_clr();
        send_frame(8'h15, 0, 0);
        send_frame(8'h16, 0, 0);
        send_frame(8'h17, 0, 0);
        send_frame(8'h18, 0, 0);
        send_frame(8'h19, 0, 0);
        check_state("full_drop");
        pulse_clr();
        check_state("full_clr");
        send_frame(8'h1A, 0, 1);
        check_state("full_pop_push");
        send_frame(8'h1B, 0, 2);
        check_state("drop_vs_clr");
        drain_all();
        check_state("full_drained");
        pulse_clr();

        for (int it = 0; it < 40; it++) begin
            sel  = $urandom_range(0, 3);
            kind = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
            if (sel == 0) b = 8'hE0;
            else if (sel == 1) b = 8'hF0;
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hE0 || b == 8'hF0) b = 8'h11;
            end
            send_frame(b, kind, 0);
            check_state($sformatf("rand%0d", it));
            for (int p = $urandom_range(0, 2); p > 0; p--) begin
                if (mq.size() > 0) pop_one();
            end
            if ($urandom_range(0, 5) == 0) pulse_clr();
        end
        drain_all();
        pulse_clr();

        send_frame(8'h31, 0, 0);
        send_frame(8'h32, 0, 0);
        send_frame(8'h33, 0, 0);
        check_state("pre_reset");
        send_bits(make_frame(8'h44, 0), 4, 0);
        check("pre_reset_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_state("async_reset");
        check("async_reset_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_frame(8'h29, 0, 0);
        check_state("post_reset");
        drain_all();

        for (int k = 0; k < 300; k++) send_frame(8'h1C, 1 + (k % 3), 0);
        check_state("err_sat");
        check("err_sat_255", err_cnt, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ps2_scan_receiver.md
# ps2_scan_receiver

Parametrised PS/2 receive path: samples the PS/2 clock/data lines, validates 11-bit frames and folds the E0 (extended) and F0 (break) prefixes into single key events. Events go into a configurable-depth FIFO and are drained through a valid/ready handshake. It replaces the fixed 8-entry, byte-level keyboard receiver in the game-input chain. It adds a bit-level watchdog, error accounting and non-destructive overflow handling.

## Interface
- FIFO_DEPTH, 16: event FIFO entries; power of two, ≥2
- SYNC_STAGES, 3: synchroniser flops on ps2_clk and ps2_data; ≥2
- TIMEOUT_CYCLES, 50000: clk cycles without a PS/2 falling edge mid-frame before the frame is aborted; ≥2
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock line (async)
- ps2_data  in  1  raw PS/2 data line (async)
- out_ready  in  1  consumer accepts the head event this cycle
- clr_ovf  in  1  clears overflow (single-cycle pulse)
- out_valid  out  1  FIFO non-empty
- out_code  out  10  head event {ext, brk, scan[7:0]}
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH
- overflow  out  1  sticky: an event was dropped on full
- err_cnt  out  8  saturating count of rejected/aborted frames
- busy  out  1  frame in progress (bit_cnt ≠ 0)

## Operation
- Both lines pass through SYNC_STAGES flops with equal delay. A falling edge is detected when the last stage is 1 and the previous stage is 0. Data is sampled from the last data stage in that same cycle.
- Frame receive:
  - bit_cnt runs 0..10. Bits are start(0), d0..d7 LSB first, odd parity, stop(1). Each detected edge shifts in one bit.
  - On the 11th edge, the frame is valid iff start==0, stop==1 and XOR(d, parity)==1.
  - bit_cnt returns to 0 regardless of validity.
- Invalid frame: data discarded, err_cnt+1 (saturates at 255), both prefix flags cleared.
- Decoder, on each valid byte:
  - E0: set ext_pend.
  - F0: set brk_pend.
  - Any other byte: emit event {ext_pend, brk_pend, byte}, then clear both flags.
  - E0/F0 are never enqueued. Sequence E0 F0 74 → event 0x374.
- Watchdog:
  - Counter clears on every detected edge and while bit_cnt==0.
  - If it reaches TIMEOUT_CYCLES while bit_cnt≠0: bit_cnt←0, err_cnt+1 (saturating). Prefix flags are kept.
- FIFO:
  - Push on emit; pop when out_valid && out_ready. out_code shows the head entry.
  - Full with no pop: the new event is dropped (the FIFO is never overwritten) and overflow←1.
  - Full with a pop in the same cycle: push accepted, level unchanged.
  - Empty with a push: level→1, no pop is possible that cycle.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. level is derived from a separate counter.
- overflow is cleared only by clr_ovf or rst. If clr_ovf coincides with a drop, the drop wins (overflow stays 1). Pops do not clear overflow.

## Timing
- Reset values: out_valid=0, level=0, overflow=0, err_cnt=0, busy=0. Prefix flags, bit_cnt, watchdog and pointers are all 0. out_code is undefined while out_valid=0. Synchroniser flops reset to 1 (idle bus).
- Reset asserted mid-frame aborts the frame immediately. The partial frame is not counted as an error.
- Edge-to-sample latency: SYNC_STAGES+1 clk after the raw ps2_clk falls.
- Valid final byte: the event is written at the clk edge ending the 11th detection cycle. out_valid=1 and level increments on the following cycle.
- Pop: out_code advances and level decrements one cycle after the handshake cycle.
- busy rises on the cycle after the first detected edge. It falls the cycle after the 11th edge or after a watchdog abort.
- One event per frame at most; throughput is bounded by the PS/2 clock, never by the FIFO.

## Test plan
- Single make code: frame 0x1C (parity 0) → out_valid=1, out_code=0x01C, level=1; pulse out_ready → out_valid=0, level=0.
- Prefix folding: frames E0, F0, 74 → exactly one event 0x374; then frame 1C → event 0x01C (flags cleared).
- Errors: frame 0x1C with wrong parity → no event, err_cnt=1. Then bad stop bit → err_cnt=2. Force 300 bad frames → err_cnt saturates at 255.
- Watchdog (TIMEOUT_CYCLES=100): send 5 bits then idle 100 clk → busy=0, err_cnt+1. Next full frame 0x2A → event 0x02A.
- Full/overflow (FIFO_DEPTH=4): 5 frames with out_ready=0 → level=4, overflow=1, the first four codes are preserved in order. Frame arriving on a pop cycle while full → accepted, level stays 4. clr_ovf → overflow=0.
- Async reset pulse mid-frame and with 3 events queued → all outputs return to reset values within the same cycle. The next frame is decoded correctly.
